// File: rtl/ext_trig_core.sv
// Trigger acceptance: masked OR/AND combine, busy/dead/run gating, prompt and delayed pulses; TRIG_TIMESTAMP_EN adds accept timestamps.
// Latency: trig_prompt follows the 3rd clock edge sampling trig_in high; trig_delayed lags trig_prompt by trig_delay cycles.
// Backpressure: none; busy_in and the dead window veto edges, which are counted in veto_count.
module ext_trig_core #(
  parameter int N_TRIG      = 8,
  parameter int CNT_W       = 32,
  parameter int DEAD_W      = 16,
  parameter int DELAY_DEPTH = 32,
  parameter int DLY_W       = $clog2(DELAY_DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [N_TRIG-1:0] trig_in,
  input  logic [N_TRIG-1:0] trig_mask,
  input  logic              trig_mode,
  input  logic              busy_in,
  input  logic              start_run,
  input  logic              stop_run,
  input  logic [DEAD_W-1:0] dead_time,
  input  logic [CNT_W-1:0]  max_trigs,
  input  logic [DLY_W-1:0]  trig_delay,
  output logic              running,
  output logic              trig_prompt,
  output logic              trig_delayed,
  output logic [CNT_W-1:0]  trig_count,
  output logic [CNT_W-1:0]  veto_count,
  output logic              led_trig,
  output logic [47:0]       trig_timestamp
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  logic                   runState;
  logic [N_TRIG-1:0]      trigS1, trigS2;
  logic                   busyS1, busyS2;
  logic                   comb, combQ, trigEdge;
  logic                   accept, veto, startEv, lastTrig;
  logic [DEAD_W-1:0]      deadCnt;
  logic [CNT_W-1:0]       trigCountNext;
  logic [DELAY_DEPTH-1:0] dlyLine;
  logic [DLY_W-1:0]       dlyTap;

  assign running = (runState == STATE_RUN);

  always_comb begin
    comb = trig_mode ? ((|trig_mask) && (&(trigS2 | ~trig_mask)))
                     : (|(trigS2 & trig_mask));
    trigEdge      = comb && !combQ;
    accept        = trigEdge && running && !stop_run && !busyS2 && (deadCnt == '0);
    veto          = trigEdge && running && !stop_run && (busyS2 || (deadCnt != '0));
    startEv       = !running && start_run && !stop_run;
    trigCountNext = (&trig_count) ? trig_count : trig_count + CNT_W'(1);
    // The accept that reaches max_trigs also ends the run on the same edge.
    lastTrig      = accept && (max_trigs != '0) && (trigCountNext == max_trigs);
    dlyTap        = trig_delay - DLY_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      runState     <= STATE_IDLE;
      trigS1       <= '0;
      trigS2       <= '0;
      busyS1       <= 1'b0;
      busyS2       <= 1'b0;
      combQ        <= 1'b0;
      deadCnt      <= '0;
      trig_count   <= '0;
      veto_count   <= '0;
      trig_prompt  <= 1'b0;
      trig_delayed <= 1'b0;
      led_trig     <= 1'b0;
      dlyLine      <= '0;
    end else begin
      trigS1      <= trig_in;
      trigS2      <= trigS1;
      busyS1      <= busy_in;
      busyS2      <= busyS1;
      combQ       <= comb;
      trig_prompt <= accept;
      if (accept)
        led_trig <= ~led_trig;

      // dlyLine[j] holds trig_prompt as it was j cycles ago.
      dlyLine      <= {dlyLine[DELAY_DEPTH-2:0], accept};
      trig_delayed <= (trig_delay == '0) ? accept : dlyLine[dlyTap];

      case (runState)
        STATE_IDLE: if (startEv) runState <= STATE_RUN;
        STATE_RUN:  if (stop_run || lastTrig) runState <= STATE_IDLE;
        default:    runState <= STATE_IDLE;
      endcase

      if (startEv) begin
        trig_count <= '0;
        veto_count <= '0;
      end else begin
        if (accept)
          trig_count <= trigCountNext;
        if (veto && !(&veto_count))
          veto_count <= veto_count + CNT_W'(1);
      end

      if (startEv)
        deadCnt <= '0;
      else if (accept)
        deadCnt <= dead_time;
      else if (deadCnt != '0)
        deadCnt <= deadCnt - DEAD_W'(1);
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [47:0] tsCnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tsCnt          <= '0;
      trig_timestamp <= '0;
    end else begin
      tsCnt <= startEv ? 48'd0 : tsCnt + 48'd1;
      if (accept)
        trig_timestamp <= tsCnt;
    end
  end
`else
  assign trig_timestamp = '0;
`endif

endmodule

// File: doc/ext_trig_core.md
Name: ext_trig_core

Overview:
Parametrised trigger-acceptance core for external trigger distribution. It combines N masked trigger inputs in OR or AND (coincidence) mode and applies busy, dead-time and run gating. It then emits a prompt accept pulse and a programmably delayed copy. It sits between the IPIF register decoder/clock converter (register fields arrive as ports) and the DDR/LVDS output primitives.

Parameters:
N_TRIG, 8, number of trigger inputs
CNT_W, 32, width of trigger/veto counters and max_trigs
DEAD_W, 16, width of dead_time
DELAY_DEPTH, 32, delay-line length; trig_delay width DLY_W = $clog2(DELAY_DEPTH)

Ports:
clock  in  1  IP clock
resetn  in  1  synchronous active-low reset
trig_in  in  N_TRIG  asynchronous trigger inputs
trig_mask  in  N_TRIG  per-input enable (1 = used)
trig_mode  in  1  0 = OR of enabled inputs, 1 = AND of enabled inputs
busy_in  in  1  asynchronous downstream busy
start_run  in  1  start request (level or pulse)
stop_run  in  1  stop request
dead_time  in  DEAD_W  post-accept dead window, in cycles
max_trigs  in  CNT_W  auto-stop count; 0 = unlimited
trig_delay  in  DLY_W  extra delay of trig_delayed versus trig_prompt
running  out  1  run FSM in RUN
trig_prompt  out  1  one-cycle accept pulse
trig_delayed  out  1  trig_prompt delayed by trig_delay cycles
trig_count  out  CNT_W  accepted triggers this run
veto_count  out  CNT_W  edges rejected by busy/dead while running
led_trig  out  1  toggles on every accept
trig_timestamp  out  48  see Optional Feature

Behaviour:
- Reset (resetn=0 at a clock edge): all outputs 0, FSM IDLE, synchronisers, edge register, dead counter and delay line cleared.
- trig_in and busy_in each pass through a 2-flop synchroniser (s1, s2).
- comb = trig_mode ? (|trig_mask && &(s2 | ~trig_mask)) : |(s2 & trig_mask). comb_q is comb registered; edge = comb && !comb_q.
- accept = edge && running && !stop_run && !busy_s2 && (dead_cnt == 0).
- Latency: trig_prompt is registered accept. It is high for exactly 1 cycle, starting after the 3rd clock edge that samples trig_in high. A held input produces a single pulse.
- Dead time: on accept, dead_cnt <= dead_time; otherwise it decrements to 0 and holds. With dead_time=D, the next edge is accepted no sooner than D cycles after the previous accept cycle. D=0 means no dead window.
- Run FSM, states IDLE and RUN:
  - IDLE->RUN: start_run && !stop_run. This clears trig_count, veto_count and dead_cnt on the same edge.
  - RUN->IDLE: stop_run, or an accept making trig_count == max_trigs (max_trigs != 0). running falls on the same edge the final count is written.
  - start_run is ignored in RUN. With start_run and stop_run both high in IDLE, stop wins.
- Counters: trig_count +1 per accept. veto_count +1 when edge && running && !stop_run && (busy_s2 || dead_cnt != 0). Both saturate at all-ones. Both hold their value in IDLE until the next start.
- Delay line: DELAY_DEPTH-bit shift register fed by accept. trig_delayed taps it so that trig_delayed equals trig_prompt shifted by trig_delay cycles; trig_delay=0 is coincident with trig_prompt.
- A trig_delay change takes effect on the next cycle. In-flight pulses are not re-timed: they may be dropped or duplicated across the change, and this is accepted behaviour.
- led_trig toggles on each accept, aligned with trig_prompt.
- resetn low mid-run: immediate full clear. Pending delayed pulses are lost and running=0.

Optional Feature:
Macro TRIG_TIMESTAMP_EN.
- Defined: a 48-bit free-running counter is cleared on the IDLE->RUN edge and increments every cycle; it wraps at 2^48. trig_timestamp latches the counter value on each accept and updates in the same cycle trig_prompt rises. It is 0 after reset.
- Undefined: the counter is not built and trig_timestamp is tied to 0.

Test Plan:
1. Reset, start_run pulse, mask=8'h01, mode=OR, trig_in[0] high 5 cycles -> trig_prompt one cycle after the 3rd sampling edge, trig_count=1, led_trig=1.
2. dead_time=10, trig_in[0] edges every 4 cycles (t=0,4,8,12) -> accepts at t=0 and t=12, veto_count=2.
3. max_trigs=3, five well-spaced edges -> trig_count=3, running falls with the 3rd accept, veto_count=0, remaining edges ignored.
4. mode=AND, mask=8'h05: bit0 alone -> no accept; bits 0 and 2 together -> one accept. mask=0 in AND mode -> never triggers.
5. trig_delay=7 -> trig_delayed exactly 7 cycles after trig_prompt; trig_delay=0 -> coincident.
6. busy_in held high during one edge -> no trig_prompt, veto_count=1. Then resetn low mid-run -> all counts and outputs 0, running=0, no trig_delayed after release.
